// File: rtl/imem_loader_pkg.sv
// Shared constants for the IMEM boot loader: FSM state codes, frame defaults and error codes.
// Imported by the loader and by anything that decodes its status outputs.
package imem_loader_pkg;

   localparam int unsigned DEPTH_DEFAULT = 4096;
   localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN0 = 3'd1;
   localparam logic [2:0] S_LEN1 = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;

   // The host channel is open from IDLE until the checksum byte has been taken.
   function automatic logic state_accepts_bytes(input logic [2:0] s);
      return (s != S_DONE) && (s != S_ERR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte channel plus IMEM write port of the boot loader.
// master = loader side, slave = host bridge / instruction memory side.
interface imem_loader_if #(
   parameter int AW = 12
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, we, waddr, wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, we, waddr, wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: MAGIC, 16-bit word count, little-endian payload, XOR checksum.
// Writes one IMEM word per four payload bytes and keeps the core in reset until a clean image is in.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter logic [7:0]  MAGIC = MAGIC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   imem_loader_if.master      bus,
   input  logic               clear,
   output logic               core_hold,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [2:0]    state_q,    state_d;
   logic [15:0]   len_q,      len_d;
   logic [15:0]   word_cnt_q, word_cnt_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [23:0]   shift_q,    shift_d;
   logic [7:0]    csum_q,     csum_d;
   logic          we_q,       we_d;
   logic [AW-1:0] waddr_q,    waddr_d;
   logic [31:0]   wdata_q,    wdata_d;
   logic [1:0]    err_code_q, err_code_d;

   logic          in_ready;
   logic          accept;
   logic [15:0]   len_full;

   assign in_ready = state_accepts_bytes(state_q);
   assign accept   = bus.in_valid & in_ready;
   assign len_full = {bus.in_data, len_q[7:0]};

   // NOTE: every variable assigned below gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      csum_d     = csum_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      err_code_d = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (accept && (bus.in_data == MAGIC)) begin
               state_d    = S_LEN0;
               csum_d     = 8'h00;
               word_cnt_d = 16'd0;
               byte_idx_d = 2'd0;
            end
         end

         S_LEN0: begin
            if (accept) begin
               len_d   = {8'h00, bus.in_data};
               state_d = S_LEN1;
            end
         end

         S_LEN1: begin
            if (accept) begin
               len_d = len_full;
               if (32'(len_full) > DEPTH) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_LEN;
               end else if (len_full == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               csum_d     = csum_q ^ bus.in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Bytes enter at the top, so after three bytes shift_q = {b2, b1, b0}.
               shift_d    = {bus.in_data, shift_q[23:8]};
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  waddr_d    = word_cnt_q[AW-1:0];
                  wdata_d    = {bus.in_data, shift_q};
                  word_cnt_d = word_cnt_q + 16'd1;
                  if ((word_cnt_q + 16'd1) == len_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end

         S_CSUM: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_ERR;
                  err_code_d = ERR_CSUM;
               end
            end
         end

         S_DONE: begin
            if (clear) begin
               state_d = S_IDLE;
            end
         end

         S_ERR: begin
            if (clear) begin
               state_d    = S_IDLE;
               err_code_d = ERR_NONE;
            end
         end

         default: begin
            state_d    = S_IDLE;
            err_code_d = ERR_NONE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         csum_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         csum_q     <= csum_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.we       = we_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;

   assign core_hold = (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of directed frames, hand-timed sequences,
// and randomized frames checked against a frame-level reference model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int DEPTH = 4096;
   localparam int AW    = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       core_hold, done, err;
   logic [1:0] err_code;

   imem_loader_if #(.AW(AW)) bus ();

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clear     (clear),
      .core_hold (core_hold),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   typedef struct {
      string        name;
      int           n;
      logic [127:0] bytes;   // byte 0 in the top 8 bits
      int           gap;
      bit           exp_done;
      logic [1:0]   exp_code;
      int           exp_nwr;
   } vec_t;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] frame_q[$];
   wr_t        got_q[$];
   wr_t        exp_q[$];
   bit         exp_done;
   logic [1:0] exp_code;
   logic       obs_done;
   logic [1:0] obs_code;
   vec_t       vecs[6];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.we === 1'b1) got_q.push_back(wr_t'{bus.waddr, bus.wdata});
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: parses frame_q as a whole frame and lists the writes and final status.
   task automatic model_frame();
      int         i;
      int         len;
      logic [7:0] cs;
      logic [31:0] word;
      exp_q.delete();
      exp_done = 1'b0;
      exp_code = 2'd0;
      i = 0;
      while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
      len = int'(frame_q[i+1]) + 256 * int'(frame_q[i+2]);
      i += 3;
      if (len > DEPTH) begin
         exp_code = 2'd1;
         return;
      end
      cs = 8'h00;
      for (int w = 0; w < len; w++) begin
         word = 32'h0;
         for (int k = 0; k < 4; k++) begin
            word = word + (32'(frame_q[i]) << (8 * k));
            cs   = cs ^ frame_q[i];
            i++;
         end
         exp_q.push_back(wr_t'{w[AW-1:0], word});
      end
      if (frame_q[i] == cs) exp_done = 1'b1;
      else                  exp_code = 2'd2;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      @(negedge clk);
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL in_ready: got=%0b expected=1 while sending byte %0h", bus.in_ready, b);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic pulse_clear_and_check(input string nm);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check({nm, " clr done"},      64'(done), 64'(0));
      check({nm, " clr err"},       64'(err), 64'(0));
      check({nm, " clr err_code"},  64'(err_code), 64'(0));
      check({nm, " clr core_hold"}, 64'(core_hold), 64'(1));
      check({nm, " clr in_ready"},  64'(bus.in_ready), 64'(1));
   endtask

   task automatic run_frame(input string nm, input int gap_max);
      int n;
      model_frame();
      got_q.delete();
      foreach (frame_q[i]) send_byte(frame_q[i], gap_max);
      repeat (3) @(negedge clk);
      obs_done = done;
      obs_code = err_code;
      check({nm, " done"},      64'(done), 64'(exp_done));
      check({nm, " err"},       64'(err), 64'(exp_code != 2'd0));
      check({nm, " err_code"},  64'(err_code), 64'(exp_code));
      check({nm, " core_hold"}, 64'(core_hold), 64'(!exp_done));
      check({nm, " in_ready"},  64'(bus.in_ready), 64'(0));
      check({nm, " nwrites"},   64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s waddr[%0d]", nm, i), 64'(got_q[i].a), 64'(exp_q[i].a));
         check($sformatf("%s wdata[%0d]", nm, i), 64'(got_q[i].d), 64'(exp_q[i].d));
      end
      pulse_clear_and_check(nm);
   endtask

   task automatic load_vec(input vec_t v);
      frame_q.delete();
      for (int i = 0; i < v.n; i++) frame_q.push_back(v.bytes[127-8*i -: 8]);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, " we"},        64'(bus.we), 64'(0));
      check({nm, " waddr"},     64'(bus.waddr), 64'(0));
      check({nm, " wdata"},     64'(bus.wdata), 64'(0));
      check({nm, " core_hold"}, 64'(core_hold), 64'(1));
      check({nm, " done"},      64'(done), 64'(0));
      check({nm, " err"},       64'(err), 64'(0));
      check({nm, " err_code"},  64'(err_code), 64'(0));
      check({nm, " in_ready"},  64'(bus.in_ready), 64'(1));
   endtask

   initial begin
      vec_t       t1;
      int         len;
      int         kind;
      logic [7:0] b;
      logic [7:0] cs;

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      vecs[0] = '{"t1_load",     12, 128'hA5_02_00_13_00_00_00_93_00_10_00_90_00000000,       0, 1'b1, 2'd0, 2};
      vecs[1] = '{"t2_badcsum",  12, 128'hA5_02_00_13_00_00_00_93_00_10_00_91_00000000,       0, 1'b0, 2'd2, 2};
      vecs[2] = '{"t3_len0",      4, 128'hA5_00_00_00_000000000000000000000000,               0, 1'b1, 2'd0, 0};
      vecs[3] = '{"t3_len0_bad",  4, 128'hA5_00_00_01_000000000000000000000000,               0, 1'b0, 2'd2, 0};
      vecs[4] = '{"t4_toolong",   3, 128'hA5_01_10_00000000000000000000000000,                0, 1'b0, 2'd1, 0};
      vecs[5] = '{"t5_junk_gaps",15, 128'h00_FF_13_A5_02_00_13_00_00_00_93_00_10_00_90_00,    3, 1'b1, 2'd0, 2};
      t1 = vecs[0];

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[v]) begin
         load_vec(vecs[v]);
         run_frame(vecs[v].name, vecs[v].gap);
         check({vecs[v].name, " tbl done"},     64'(obs_done), 64'(vecs[v].exp_done));
         check({vecs[v].name, " tbl err_code"}, 64'(obs_code), 64'(vecs[v].exp_code));
         check({vecs[v].name, " tbl nwrites"},  64'(got_q.size()), 64'(vecs[v].exp_nwr));
      end

      // Hand-timed test-1 frame: write pulse timing, clear ignored mid-frame, core_hold release.
      load_vec(t1);
      for (int i = 0; i < 3; i++) send_byte(frame_q[i], 0);
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      check("hand clear_ignored in_ready", 64'(bus.in_ready), 64'(1));
      for (int i = 3; i < 7; i++) send_byte(frame_q[i], 0);
      @(negedge clk);
      check("hand w0 we",    64'(bus.we), 64'(1));
      check("hand w0 waddr", 64'(bus.waddr), 64'(0));
      check("hand w0 wdata", 64'(bus.wdata), 64'(32'h0000_0013));
      @(negedge clk);
      check("hand w0 we_pulse", 64'(bus.we), 64'(0));
      for (int i = 7; i < 11; i++) send_byte(frame_q[i], 1);
      @(negedge clk);
      check("hand w1 we",    64'(bus.we), 64'(1));
      check("hand w1 waddr", 64'(bus.waddr), 64'(1));
      check("hand w1 wdata", 64'(bus.wdata), 64'(32'h0010_0093));
      check("hand pre_csum core_hold", 64'(core_hold), 64'(1));
      send_byte(frame_q[11], 0);
      @(negedge clk);
      check("hand done",      64'(done), 64'(1));
      check("hand core_hold", 64'(core_hold), 64'(0));
      pulse_clear_and_check("hand");

      // Asynchronous reset mid-word (5 payload bytes in), then a clean reload from address 0.
      for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_vec(t1);
      run_frame("after_rst", 1);

      // LEN == DEPTH boundary.
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(DEPTH));
      frame_q.push_back(8'(DEPTH >> 8));
      cs = 8'h00;
      for (int i = 0; i < 4 * DEPTH; i++) begin
         b = 8'($urandom);
         cs = cs ^ b;
         frame_q.push_back(b);
      end
      frame_q.push_back(cs);
      run_frame("len_eq_depth", 0);

      // Randomized frames: junk prefix, random lengths, corrupted checksums, oversize lengths, gaps.
      for (int f = 0; f < 30; f++) begin
         frame_q.delete();
         repeat ($urandom_range(3, 0)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            frame_q.push_back(b);
         end
         kind = $urandom_range(9, 0);
         frame_q.push_back(8'hA5);
         if (kind == 0) begin
            len = $urandom_range(65535, DEPTH + 1);
            frame_q.push_back(8'(len));
            frame_q.push_back(8'(len >> 8));
         end else begin
            len = $urandom_range(6, 0);
            frame_q.push_back(8'(len));
            frame_q.push_back(8'(len >> 8));
            cs = 8'h00;
            for (int i = 0; i < 4 * len; i++) begin
               b = 8'($urandom);
               cs = cs ^ b;
               frame_q.push_back(b);
            end
            if (kind == 1) cs = cs ^ (8'h01 << $urandom_range(7, 0));
            frame_q.push_back(cs);
         end
         run_frame($sformatf("rand%0d", f), $urandom_range(3, 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
